// File: rtl/conv_accum_pkg.sv
// Shared constants, tag type and saturation-limit helpers for the conv_accum
// post-multiplier accumulate/requantize pipeline.
package conv_accum_pkg;

  localparam int DEF_M     = 8;
  localparam int DEF_CH    = 3;
  localparam int DEF_ACC_W = 24;
  localparam int DEF_OUT_W = 8;
  localparam int PIPE_LAT  = 4;

  typedef struct packed {
    logic [4:0] row;
    logic [4:0] col;
  } tag_t;

  function automatic longint sat_umax(input int w);
    return (longint'(1) << w) - 1;
  endfunction

  function automatic longint sat_smax(input int w);
    return (longint'(1) << (w - 1)) - 1;
  endfunction

  function automatic longint sat_smin(input int w);
    return -(longint'(1) << (w - 1));
  endfunction

endpackage

// File: rtl/conv_accum_if.sv
// Product/tag bundle into the accumulator and the requantized pixel stream out.
interface conv_accum_if #(
  parameter int M     = 8,
  parameter int ACC_W = 24,
  parameter int OUT_W = 8
);
  logic                    valid_in;
  logic                    clear;
  logic                    done_in;
  logic [4:0]              row_in;
  logic [4:0]              col_in;
  logic signed [2*M-1:0]   d11, d12, d13, d21, d22, d23, d31, d32, d33;
  logic signed [ACC_W-1:0] bias;
  logic [4:0]              shift;
  logic                    relu_en;
  logic                    valid_out;
  logic                    done_out;
  logic [4:0]              row_out;
  logic [4:0]              col_out;
  logic [OUT_W-1:0]        dout;

  modport master (
    output valid_in, clear, done_in, row_in, col_in,
    output d11, d12, d13, d21, d22, d23, d31, d32, d33,
    output bias, shift, relu_en,
    input  valid_out, done_out, row_out, col_out, dout
  );

  modport slave (
    input  valid_in, clear, done_in, row_in, col_in,
    input  d11, d12, d13, d21, d22, d23, d31, d32, d33,
    input  bias, shift, relu_en,
    output valid_out, done_out, row_out, col_out, dout
  );
endinterface

// File: rtl/conv_accum_requant_sat.sv
// Requantization: floor arithmetic right shift, then ReLU/unsigned or signed
// saturation into OUT_W bits. Purely combinational; the caller registers it.
module requant_sat
  import conv_accum_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic signed [ACC_W-1:0] acc_i,
  input  logic [4:0]              shift_i,
  input  logic                    relu_en_i,
  output logic [OUT_W-1:0]        dout_o
);
  localparam longint UMAX_L = sat_umax(OUT_W);
  localparam longint SMAX_L = sat_smax(OUT_W);
  localparam longint SMIN_L = sat_smin(OUT_W);

  logic signed [ACC_W-1:0] shifted;
  logic signed [63:0]      wide;

  assign shifted = acc_i >>> shift_i;
  assign wide    = 64'(shifted);

  always_comb begin
    dout_o = wide[OUT_W-1:0];
    if (relu_en_i) begin
      if (wide < 0)           dout_o = '0;
      else if (wide > UMAX_L) dout_o = '1;
    end else begin
      if (wide > SMAX_L)      dout_o = {1'b0, {(OUT_W-1){1'b1}}};
      else if (wide < SMIN_L) dout_o = {1'b1, {(OUT_W-1){1'b0}}};
    end
  end
endmodule

// File: rtl/conv_accum.sv
// Four-stage accumulator: row sums, window sum, per-pixel channel accumulation
// with bias, then requantization. No backpressure; one beat per cycle.
module conv_accum
  import conv_accum_pkg::*;
#(
  parameter int M     = DEF_M,
  parameter int CH    = DEF_CH,
  parameter int ACC_W = DEF_ACC_W,
  parameter int OUT_W = DEF_OUT_W
) (
  input logic       clk,
  input logic       rst_n,
  conv_accum_if.slave bus
);
  localparam int CNT_W = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [CNT_W-1:0] LAST_CH = CNT_W'(CH - 1);

  logic signed [2*M-1:0]   prod [9];
  logic signed [ACC_W-1:0] row_sum_d [3];
  logic signed [ACC_W-1:0] row_sum_q [3];
  logic                    s1_valid_q, s2_valid_q;
  tag_t                    s1_tag_q, s2_tag_q, s3_tag_q, out_tag_q;
  logic signed [ACC_W-1:0] s1_bias_q, s2_bias_q;
  logic signed [ACC_W-1:0] win_d, win_q;
  logic signed [ACC_W-1:0] acc_d, acc_q;
  logic [CNT_W-1:0]        ch_cnt_d, ch_cnt_q;
  logic                    pix_done_d, s3_done_q;
  logic [OUT_W-1:0]        rq_dout, dout_q;
  logic                    valid_out_q;
  logic [PIPE_LAT-1:0]     done_q;

  assign prod[0] = bus.d11;
  assign prod[1] = bus.d12;
  assign prod[2] = bus.d13;
  assign prod[3] = bus.d21;
  assign prod[4] = bus.d22;
  assign prod[5] = bus.d23;
  assign prod[6] = bus.d31;
  assign prod[7] = bus.d32;
  assign prod[8] = bus.d33;

  for (genvar gi = 0; gi < 3; gi++) begin : g_row
    assign row_sum_d[gi] = ACC_W'(prod[3*gi]) + ACC_W'(prod[3*gi+1]) + ACC_W'(prod[3*gi+2]);
  end

  assign win_d = row_sum_q[0] + row_sum_q[1] + row_sum_q[2];

  // Clear wins over a same-cycle valid beat: the beat is simply not accumulated.
  always_comb begin
    acc_d      = acc_q;
    ch_cnt_d   = ch_cnt_q;
    pix_done_d = 1'b0;
    if (bus.clear) begin
      acc_d    = '0;
      ch_cnt_d = '0;
    end else if (s2_valid_q) begin
      acc_d      = (ch_cnt_q == '0) ? s2_bias_q + win_q : acc_q + win_q;
      pix_done_d = (ch_cnt_q == LAST_CH);
      ch_cnt_d   = pix_done_d ? '0 : ch_cnt_q + CNT_W'(1);
    end
  end

  requant_sat #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_requant_sat (
    .acc_i     (acc_q),
    .shift_i   (bus.shift),
    .relu_en_i (bus.relu_en),
    .dout_o    (rq_dout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_tag_q    <= '0;
      s1_bias_q   <= '0;
      for (int i = 0; i < 3; i++) row_sum_q[i] <= '0;
      s2_valid_q  <= 1'b0;
      s2_tag_q    <= '0;
      s2_bias_q   <= '0;
      win_q       <= '0;
      acc_q       <= '0;
      ch_cnt_q    <= '0;
      s3_done_q   <= 1'b0;
      s3_tag_q    <= '0;
      valid_out_q <= 1'b0;
      dout_q      <= '0;
      out_tag_q   <= '0;
      done_q      <= '0;
    end else begin
      s1_valid_q <= bus.valid_in & ~bus.clear;
      s1_tag_q   <= tag_t'{row: bus.row_in, col: bus.col_in};
      s1_bias_q  <= bus.bias;
      for (int i = 0; i < 3; i++) row_sum_q[i] <= row_sum_d[i];
      s2_valid_q <= s1_valid_q & ~bus.clear;
      s2_tag_q   <= s1_tag_q;
      s2_bias_q  <= s1_bias_q;
      win_q      <= win_d;
      acc_q      <= acc_d;
      ch_cnt_q   <= ch_cnt_d;
      s3_done_q  <= pix_done_d;
      if (pix_done_d) s3_tag_q <= s2_tag_q;
      valid_out_q <= s3_done_q & ~bus.clear;
      if (s3_done_q) begin
        dout_q    <= rq_dout;
        out_tag_q <= s3_tag_q;
      end
      done_q <= {done_q[PIPE_LAT-2:0], bus.done_in};
    end
  end

  assign bus.valid_out = valid_out_q;
  assign bus.dout      = dout_q;
  assign bus.row_out   = out_tag_q.row;
  assign bus.col_out   = out_tag_q.col;
  assign bus.done_out  = done_q[PIPE_LAT-1];
endmodule

// File: tb/tb_conv_accum.sv
// Drives a CH=3 and a CH=1 conv_accum with identical stimulus and checks both
// against a time-scheduled behavioural model plus hand-computed scenarios.
module tb_conv_accum;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv_accum_if #(.M(8), .ACC_W(24), .OUT_W(8)) bus3 ();
  conv_accum_if #(.M(8), .ACC_W(24), .OUT_W(8)) bus1 ();

  conv_accum #(.M(8), .CH(3), .ACC_W(24), .OUT_W(8)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));
  conv_accum #(.M(8), .CH(1), .ACC_W(24), .OUT_W(8)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  assign bus1.valid_in = bus3.valid_in;
  assign bus1.clear    = bus3.clear;
  assign bus1.done_in  = bus3.done_in;
  assign bus1.row_in   = bus3.row_in;
  assign bus1.col_in   = bus3.col_in;
  assign bus1.d11 = bus3.d11;
  assign bus1.d12 = bus3.d12;
  assign bus1.d13 = bus3.d13;
  assign bus1.d21 = bus3.d21;
  assign bus1.d22 = bus3.d22;
  assign bus1.d23 = bus3.d23;
  assign bus1.d31 = bus3.d31;
  assign bus1.d32 = bus3.d32;
  assign bus1.d33 = bus3.d33;
  assign bus1.bias    = bus3.bias;
  assign bus1.shift   = bus3.shift;
  assign bus1.relu_en = bus3.relu_en;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    longint     win;
    longint     bias;
    logic [4:0] row;
    logic [4:0] col;
    int         edge_no;
  } beat_t;

  beat_t      pend[$];
  int         chs[2] = '{3, 1};
  longint     m_acc[2];
  int         m_cnt[2];
  bit         stg_v[2], exp_v[2];
  logic [7:0] stg_d[2], exp_d[2];
  logic [4:0] stg_r[2], stg_c[2], exp_r[2], exp_c[2];
  bit [3:0]   done_hist;
  int         k_edge = 0;

  function automatic logic [7:0] requant(input longint acc, input int sh, input bit relu);
    longint v;
    v = acc >>> sh;
    if (relu) begin
      if (v < 0) v = 0;
      else if (v > 255) v = 255;
    end else begin
      if (v > 127) v = 127;
      else if (v < -128) v = -128;
    end
    return v[7:0];
  endfunction

  function automatic longint window_sum();
    return longint'(bus3.d11) + longint'(bus3.d12) + longint'(bus3.d13)
         + longint'(bus3.d21) + longint'(bus3.d22) + longint'(bus3.d23)
         + longint'(bus3.d31) + longint'(bus3.d32) + longint'(bus3.d33);
  endfunction

  // A beat accepted at edge e is folded into the pixel at edge e+2 and its
  // pixel result becomes visible after edge e+3; any clear in between kills it.
  initial begin
    beat_t b;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        pend.delete();
        done_hist = '0;
        for (int u = 0; u < 2; u++) begin
          m_acc[u] = 0; m_cnt[u] = 0; stg_v[u] = 0; exp_v[u] = 0;
          exp_d[u] = '0; exp_r[u] = '0; exp_c[u] = '0;
        end
      end else begin
        k_edge++;
        done_hist = {done_hist[2:0], bus3.done_in};
        if (bus3.clear) begin
          pend.delete();
          for (int u = 0; u < 2; u++) begin
            m_acc[u] = 0; m_cnt[u] = 0; stg_v[u] = 0; exp_v[u] = 0;
          end
        end else begin
          for (int u = 0; u < 2; u++) begin
            exp_v[u] = stg_v[u];
            if (stg_v[u]) begin
              exp_d[u] = stg_d[u]; exp_r[u] = stg_r[u]; exp_c[u] = stg_c[u];
            end
            stg_v[u] = 0;
          end
          if (pend.size() > 0 && pend[0].edge_no == k_edge - 2) begin
            b = pend.pop_front();
            for (int u = 0; u < 2; u++) begin
              m_acc[u] = (m_cnt[u] == 0) ? b.bias + b.win : m_acc[u] + b.win;
              m_cnt[u]++;
              if (m_cnt[u] == chs[u]) begin
                m_cnt[u] = 0;
                stg_v[u] = 1;
                stg_d[u] = requant(m_acc[u], int'(bus3.shift), bus3.relu_en);
                stg_r[u] = b.row;
                stg_c[u] = b.col;
              end
            end
          end
          if (bus3.valid_in) begin
            b.win = window_sum(); b.bias = longint'(bus3.bias);
            b.row = bus3.row_in; b.col = bus3.col_in; b.edge_no = k_edge;
            pend.push_back(b);
          end
        end
      end
    end
  end

  task automatic cmp(input string nm, input int u, input logic v, input logic [7:0] d,
                     input logic [4:0] r, input logic [4:0] c, input logic dn);
    chk({nm, "_valid_out"}, 32'(v), 32'(exp_v[u]));
    chk({nm, "_done_out"}, 32'(dn), 32'(done_hist[3]));
    if (exp_v[u]) begin
      chk({nm, "_dout"}, 32'(d), 32'(exp_d[u]));
      chk({nm, "_row_out"}, 32'(r), 32'(exp_r[u]));
      chk({nm, "_col_out"}, 32'(c), 32'(exp_c[u]));
      $display("pixel %s row=%0d col=%0d dout=%0d", nm, r, c, d);
    end
    if (!rst_n) begin
      chk({nm, "_dout_rst"}, 32'(d), 0);
      chk({nm, "_row_rst"}, 32'(r), 0);
      chk({nm, "_col_rst"}, 32'(c), 0);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cmp("ch3", 0, bus3.valid_out, bus3.dout, bus3.row_out, bus3.col_out, bus3.done_out);
      cmp("ch1", 1, bus1.valid_out, bus1.dout, bus1.row_out, bus1.col_out, bus1.done_out);
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_in(input bit v, input bit clr, input bit dn, input int w, input bit spread,
                        input int b, input int r, input int c);
    bus3.valid_in = v;
    bus3.clear    = clr;
    bus3.done_in  = dn;
    bus3.d11 = 16'(w);
    bus3.d12 = spread ? 16'(w) : 16'sd0;
    bus3.d13 = spread ? 16'(w) : 16'sd0;
    bus3.d21 = spread ? 16'(w) : 16'sd0;
    bus3.d22 = spread ? 16'(w) : 16'sd0;
    bus3.d23 = spread ? 16'(w) : 16'sd0;
    bus3.d31 = spread ? 16'(w) : 16'sd0;
    bus3.d32 = spread ? 16'(w) : 16'sd0;
    bus3.d33 = spread ? 16'(w) : 16'sd0;
    bus3.bias   = 24'(b);
    bus3.row_in = 5'(r);
    bus3.col_in = 5'(c);
  endtask

  task automatic step(input bit v, input bit clr, input int w, input int b, input int r, input int c);
    set_in(v, clr, 1'b0, w, 1'b0, b, r, c);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      set_in(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0, 0);
      @(negedge clk);
    end
  endtask

  task automatic rand_step();
    bus3.valid_in = ($urandom_range(0, 99) < 75);
    bus3.clear    = ($urandom_range(0, 99) < 4);
    bus3.done_in  = ($urandom_range(0, 99) < 10);
    bus3.d11 = 16'($urandom); bus3.d12 = 16'($urandom); bus3.d13 = 16'($urandom);
    bus3.d21 = 16'($urandom); bus3.d22 = 16'($urandom); bus3.d23 = 16'($urandom);
    bus3.d31 = 16'($urandom); bus3.d32 = 16'($urandom); bus3.d33 = 16'($urandom);
    bus3.bias   = 24'(int'($urandom_range(0, 2097151)) - 1048576);
    bus3.row_in = 5'($urandom);
    bus3.col_in = 5'($urandom);
    @(negedge clk);
  endtask

  initial begin
    set_in(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0, 0);
    bus3.shift = 5'd0;
    bus3.relu_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid_out", 32'(bus3.valid_out), 0);
    chk("rst_dout", 32'(bus3.dout), 0);
    chk("rst_done_out", 32'(bus3.done_out), 0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Single-channel pixel of nine ones: 9, exactly four cycles after the beat.
    bus3.relu_en = 1'b1;
    step(1'b0, 1'b1, 0, 0, 0, 0);
    set_in(1'b1, 1'b0, 1'b0, 1, 1'b1, 0, 2, 3);
    @(negedge clk);
    idle(2);
    chk("ch1_early_valid", 32'(bus1.valid_out), 0);
    idle(1);
    chk("ch1_lat4_valid", 32'(bus1.valid_out), 1);
    chk("ch1_ones_dout", 32'(bus1.dout), 9);
    idle(3);

    // 10 + 100 + 200 - 50 = 260, >>> 2 = 65, tags of the third beat.
    bus3.shift = 5'd2;
    step(1'b0, 1'b1, 0, 0, 0, 0);
    step(1'b1, 1'b0, 100, 10, 1, 1);
    step(1'b1, 1'b0, 200, 999, 2, 2);
    step(1'b1, 1'b0, -50, 777, 7, 9);
    idle(3);
    chk("ch3_sum_valid", 32'(bus3.valid_out), 1);
    chk("ch3_sum_dout", 32'(bus3.dout), 65);
    chk("ch3_sum_row", 32'(bus3.row_out), 7);
    chk("ch3_sum_col", 32'(bus3.col_out), 9);
    idle(1);
    chk("ch3_sum_once", 32'(bus3.valid_out), 0);
    idle(2);

    // Same pixel with bubbles between channels.
    step(1'b0, 1'b1, 0, 0, 0, 0);
    step(1'b1, 1'b0, 100, 10, 1, 1);
    idle(1);
    step(1'b1, 1'b0, 200, 999, 2, 2);
    idle(1);
    step(1'b1, 1'b0, -50, 777, 7, 9);
    idle(3);
    chk("bubble_valid", 32'(bus3.valid_out), 1);
    chk("bubble_dout", 32'(bus3.dout), 65);
    chk("bubble_row", 32'(bus3.row_out), 7);
    idle(2);

    // Clear after channel 1 (same-cycle beat dropped); restart loads bias 20: 35 >>> 2 = 8.
    step(1'b0, 1'b1, 0, 0, 0, 0);
    step(1'b1, 1'b0, 100, 10, 1, 1);
    step(1'b1, 1'b1, 100, 10, 1, 1);
    step(1'b1, 1'b0, 5, 20, 3, 4);
    step(1'b1, 1'b0, 5, 0, 4, 4);
    step(1'b1, 1'b0, 5, 0, 5, 6);
    idle(3);
    chk("restart_valid", 32'(bus3.valid_out), 1);
    chk("restart_dout", 32'(bus3.dout), 8);
    chk("restart_col", 32'(bus3.col_out), 6);
    idle(2);

    // -300 with ReLU -> 0; without ReLU, shift 0 -> -128.
    bus3.shift = 5'd0;
    bus3.relu_en = 1'b1;
    step(1'b0, 1'b1, 0, 0, 0, 0);
    repeat (3) step(1'b1, 1'b0, -100, 0, 1, 2);
    idle(3);
    chk("neg_relu_dout", 32'(bus3.dout), 0);
    idle(2);
    bus3.relu_en = 1'b0;
    step(1'b0, 1'b1, 0, 0, 0, 0);
    repeat (3) step(1'b1, 1'b0, -100, 0, 1, 2);
    idle(3);
    chk("neg_signed_dout", 32'(bus3.dout), 32'h80);
    idle(2);

    // 100000 >>> 4 = 6250 -> 255 under ReLU saturation.
    bus3.shift = 5'd4;
    bus3.relu_en = 1'b1;
    step(1'b0, 1'b1, 0, 0, 0, 0);
    step(1'b1, 1'b0, 30000, 10000, 3, 3);
    step(1'b1, 1'b0, 30000, 0, 3, 3);
    step(1'b1, 1'b0, 30000, 0, 3, 3);
    idle(3);
    chk("big_sat_dout", 32'(bus3.dout), 255);
    idle(2);

    // Reset mid-accumulation, then done latency and a fresh channel-0 start.
    bus3.shift = 5'd0;
    bus3.relu_en = 1'b0;
    step(1'b0, 1'b1, 0, 0, 0, 0);
    step(1'b1, 1'b0, 10, 0, 1, 1);
    step(1'b1, 1'b0, 20, 0, 1, 1);
    set_in(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_dout", 32'(bus3.dout), 0);
    chk("async_rst_row", 32'(bus3.row_out), 0);
    chk("async_rst_valid", 32'(bus1.valid_out), 0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    set_in(1'b0, 1'b0, 1'b1, 0, 1'b0, 0, 0, 0);
    @(negedge clk);
    idle(2);
    chk("done_early", 32'(bus3.done_out), 0);
    idle(1);
    chk("done_lat4", 32'(bus3.done_out), 1);
    step(1'b1, 1'b0, 7, 3, 4, 5);
    step(1'b1, 1'b0, 7, 0, 4, 5);
    step(1'b1, 1'b0, 7, 0, 4, 5);
    idle(3);
    chk("post_rst_dout", 32'(bus3.dout), 24);
    idle(4);

    // Randomized traffic; shift and ReLU held per segment.
    for (int seg = 0; seg < 10; seg++) begin
      bus3.shift = 5'($urandom_range(0, 12));
      bus3.relu_en = 1'($urandom_range(0, 1));
      repeat (200) rand_step();
      idle(6);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
